// File: rtl/pixel_pkg.sv
// Shared constants and the state type for the pixel histogram block.
package pixel_pkg;

  localparam int PIX_W_DEFAULT = 8;
  localparam int CNT_W_DEFAULT = 20;
  localparam int NBINS         = 256;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_ACCUM,
    ST_DRAIN,
    ST_READOUT
  } hist_state_t;

endpackage

// File: rtl/hist_ram.sv
// 1R1W simple dual-port RAM with synchronous read and no reset, kept plain so it maps to block RAM.
module hist_ram
  import pixel_pkg::*;
#(
  parameter int AW = PIX_W_DEFAULT,
  parameter int DW = CNT_W_DEFAULT
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [2**AW];

  // Read returns the pre-write contents when both ports hit the same address.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/pixel_histogram.sv
// Per-frame 256-bin intensity histogram: clear, accumulate, then stream bins out over valid/ready.
// Optional macro HIST_CUMULATIVE_EN makes rd_count a saturating running sum (CDF) instead of raw counts.
module pixel_histogram
  import pixel_pkg::*;
#(
  parameter int PIX_W = PIX_W_DEFAULT,
  parameter int CNT_W = CNT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             pix_valid,
  input  logic [PIX_W-1:0] pix_in,
  input  logic             pix_last,
  output logic             pix_ready,
  output logic             busy,
  output logic             rd_valid,
  input  logic             rd_ready,
  output logic [PIX_W-1:0] rd_bin,
  output logic [CNT_W-1:0] rd_count,
  output logic             rd_last,
  output logic             sat
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  hist_state_t      state_reg, state_next;
  logic [PIX_W:0]   addr_reg;
  logic             drain_reg;

  logic             s1_valid_reg;
  logic [PIX_W-1:0] s1_addr_reg;
  logic             s2_valid_reg;
  logic [PIX_W-1:0] s2_addr_reg;
  logic [CNT_W-1:0] s2_count_reg;

  logic             r1_valid_reg;
  logic [PIX_W-1:0] r1_bin_reg;
  logic             rd_valid_reg, rd_last_reg, sat_reg;
  logic [PIX_W-1:0] rd_bin_reg;
  logic [CNT_W-1:0] rd_count_reg;

  logic             ram_we, ram_re;
  logic [PIX_W-1:0] ram_waddr, ram_raddr;
  logic [CNT_W-1:0] ram_wdata, ram_rdata;

  logic             accept, out_load, r1_move, issue;
  logic [CNT_W-1:0] base, inc_val, out_val;
  logic             inc_sat, out_sat;

  assign accept   = pix_valid && (state_reg == ST_ACCUM);
  assign out_load = !rd_valid_reg || rd_ready;
  assign r1_move  = r1_valid_reg && out_load;
  // The RAM output register doubles as the prefetch stage: only refill it once its word is leaving.
  assign issue    = (state_reg == ST_READOUT) && !addr_reg[PIX_W] && (!r1_valid_reg || out_load);

  // A pixel one beat behind the same bin would read stale RAM data; take the pending write instead.
  assign base    = (s2_valid_reg && (s2_addr_reg == s1_addr_reg)) ? s2_count_reg : ram_rdata;
  assign inc_sat = (base == CNT_MAX);
  assign inc_val = inc_sat ? base : base + 1'b1;

  always_comb begin
    ram_we    = s1_valid_reg;
    ram_waddr = s1_addr_reg;
    ram_wdata = inc_val;
    if (state_reg == ST_CLEAR) begin
      ram_we    = 1'b1;
      ram_waddr = addr_reg[PIX_W-1:0];
      ram_wdata = '0;
    end
    ram_re    = accept || issue;
    ram_raddr = (state_reg == ST_READOUT) ? addr_reg[PIX_W-1:0] : pix_in;
  end

  hist_ram #(.AW(PIX_W), .DW(CNT_W)) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdata (ram_wdata),
    .re    (ram_re),
    .raddr (ram_raddr),
    .rdata (ram_rdata)
  );

`ifdef HIST_CUMULATIVE_EN
  logic [CNT_W-1:0] cum_reg;
  logic [CNT_W:0]   cum_sum;

  always_comb begin
    cum_sum = {1'b0, cum_reg} + {1'b0, ram_rdata};
    out_sat = cum_sum[CNT_W];
    out_val = out_sat ? CNT_MAX : cum_sum[CNT_W-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                     cum_reg <= '0;
    else if (state_reg == ST_DRAIN) cum_reg <= '0;
    else if (r1_move)               cum_reg <= out_val;
  end
`else
  assign out_val = ram_rdata;
  assign out_sat = 1'b0;
`endif

  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      ST_IDLE:    if (start) state_next = ST_CLEAR;
      ST_CLEAR:   if (&addr_reg[PIX_W-1:0]) state_next = ST_ACCUM;
      ST_ACCUM:   if (accept && pix_last) state_next = ST_DRAIN;
      ST_DRAIN:   if (drain_reg) state_next = ST_READOUT;
      ST_READOUT: if (rd_valid_reg && rd_ready && rd_last_reg) state_next = ST_IDLE;
      default:    state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
      addr_reg  <= '0;
      drain_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      drain_reg <= (state_reg == ST_DRAIN) && !drain_reg;
      case (state_reg)
        ST_CLEAR:   addr_reg <= addr_reg + 1'b1;
        ST_READOUT: if (issue) addr_reg <= addr_reg + 1'b1;
        default:    addr_reg <= '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_reg <= 1'b0;
      s1_addr_reg  <= '0;
      s2_valid_reg <= 1'b0;
      s2_addr_reg  <= '0;
      s2_count_reg <= '0;
    end else begin
      s1_valid_reg <= accept;
      if (accept) s1_addr_reg <= pix_in;
      s2_valid_reg <= s1_valid_reg;
      s2_addr_reg  <= s1_addr_reg;
      s2_count_reg <= inc_val;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sat_reg <= 1'b0;
    end else if ((state_reg == ST_IDLE) && start) begin
      sat_reg <= 1'b0;
    end else if ((s1_valid_reg && inc_sat) || (r1_move && out_sat)) begin
      sat_reg <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r1_valid_reg <= 1'b0;
      r1_bin_reg   <= '0;
    end else if (state_reg != ST_READOUT) begin
      r1_valid_reg <= 1'b0;
    end else if (issue) begin
      r1_valid_reg <= 1'b1;
      r1_bin_reg   <= addr_reg[PIX_W-1:0];
    end else if (r1_move) begin
      r1_valid_reg <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_valid_reg <= 1'b0;
      rd_last_reg  <= 1'b0;
      rd_bin_reg   <= '0;
      rd_count_reg <= '0;
    end else if (state_reg != ST_READOUT) begin
      rd_valid_reg <= 1'b0;
      rd_last_reg  <= 1'b0;
      rd_bin_reg   <= '0;
      rd_count_reg <= '0;
    end else if (out_load) begin
      rd_valid_reg <= r1_valid_reg;
      rd_last_reg  <= r1_valid_reg && (&r1_bin_reg);
      if (r1_valid_reg) begin
        rd_bin_reg   <= r1_bin_reg;
        rd_count_reg <= out_val;
      end
    end
  end

  assign pix_ready = (state_reg == ST_ACCUM);
  assign busy      = (state_reg != ST_IDLE);
  assign rd_valid  = rd_valid_reg;
  assign rd_bin    = rd_bin_reg;
  assign rd_count  = rd_count_reg;
  assign rd_last   = rd_last_reg;
  assign sat       = sat_reg;

endmodule

// File: tb/tb_pixel_histogram.sv
// Drives two histogram instances (20-bit and 4-bit counters) with one stimulus stream and checks both against a per-bin array model.
module tb_pixel_histogram;

  localparam int CNT_W   = 20;
  localparam int CNT_W_S = 4;
  localparam int MAX_L   = (1 << CNT_W) - 1;
  localparam int MAX_S   = (1 << CNT_W_S) - 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic pix_valid = 1'b0;
  logic pix_last = 1'b0;
  logic rd_ready = 1'b0;
  logic [7:0] pix_in = 8'd0;

  logic pix_ready, busy, rd_valid, rd_last, sat;
  logic [7:0] rd_bin;
  logic [CNT_W-1:0] rd_count;
  logic pix_ready_s, busy_s, rd_valid_s, rd_last_s, sat_s;
  logic [7:0] rd_bin_s;
  logic [CNT_W_S-1:0] rd_count_s;

  int hist [256];
  int pix_q [$];
  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  pixel_histogram #(.PIX_W(8), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .pix_valid(pix_valid), .pix_in(pix_in),
    .pix_last(pix_last), .pix_ready(pix_ready), .busy(busy), .rd_valid(rd_valid),
    .rd_ready(rd_ready), .rd_bin(rd_bin), .rd_count(rd_count), .rd_last(rd_last), .sat(sat)
  );

  pixel_histogram #(.PIX_W(8), .CNT_W(CNT_W_S)) dut_s (
    .clk(clk), .rst_n(rst_n), .start(start), .pix_valid(pix_valid), .pix_in(pix_in),
    .pix_last(pix_last), .pix_ready(pix_ready_s), .busy(busy_s), .rd_valid(rd_valid_s),
    .rd_ready(rd_ready), .rd_bin(rd_bin_s), .rd_count(rd_count_s), .rd_last(rd_last_s), .sat(sat_s)
  );

  task automatic check(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Expected readout word for bin b when counters saturate at maxv.
  function automatic int exp_count(int b, int maxv);
    longint s = 0;
`ifdef HIST_CUMULATIVE_EN
    for (int i = 0; i <= b; i++) s += (hist[i] > maxv) ? maxv : hist[i];
`else
    s = (hist[b] > maxv) ? maxv : hist[b];
`endif
    return (s > maxv) ? maxv : int'(s);
  endfunction

  function automatic int exp_sat(int maxv);
    longint tot = 0;
    int s = 0;
    for (int i = 0; i < 256; i++) begin
      if (hist[i] > maxv) s = 1;
      tot += (hist[i] > maxv) ? maxv : hist[i];
    end
`ifdef HIST_CUMULATIVE_EN
    if (tot > maxv) s = 1;
`endif
    return s;
  endfunction

  // Pulse start and wait for ACCUM, feeding junk pixels that must be ignored during CLEAR.
  task automatic start_frame(input string name);
    int k;
    foreach (hist[i]) hist[i] = 0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    k = 1;
    check({name, ".busy_after_start"}, busy, 1);
    while (!pix_ready && k < 300) begin
      pix_valid = 1'($urandom_range(0, 1));
      pix_in    = 8'($urandom);
      pix_last  = 1'($urandom_range(0, 1));
      @(negedge clk);
      k++;
    end
    pix_valid = 1'b0;
    pix_last  = 1'b0;
    // One edge to enter CLEAR plus 256 clear cycles.
    check({name, ".clear_len"}, k, 257);
  endtask

  task automatic send_pixels(input int gap_pct, input bit with_last);
    for (int i = 0; i < pix_q.size(); i++) begin
      while ($urandom_range(0, 99) < gap_pct) begin
        pix_valid = 1'b0;
        pix_last  = 1'($urandom_range(0, 1));
        @(negedge clk);
      end
      pix_valid = 1'b1;
      pix_in    = 8'(pix_q[i]);
      pix_last  = with_last && (i == pix_q.size() - 1);
      hist[pix_q[i]]++;
      @(negedge clk);
    end
    pix_valid = 1'b0;
    pix_last  = 1'b0;
  endtask

  task automatic readout(input string name, input int ready_pct, output int cyc);
    int hs = 0;
    int hs_s = 0;
    cyc = 0;
    while ((hs < 256 || hs_s < 256) && cyc < 4000) begin
      if (rd_valid) begin
        if (hs < 256) begin
          check({name, ".bin"}, rd_bin, hs);
          check({name, ".count"}, rd_count, exp_count(hs, MAX_L));
          check({name, ".last"}, rd_last, (hs == 255));
        end else check({name, ".extra_word"}, rd_valid, 0);
      end
      if (rd_valid_s) begin
        if (hs_s < 256) begin
          check({name, ".bin_s"}, rd_bin_s, hs_s);
          check({name, ".count_s"}, rd_count_s, exp_count(hs_s, MAX_S));
          check({name, ".last_s"}, rd_last_s, (hs_s == 255));
        end else check({name, ".extra_word_s"}, rd_valid_s, 0);
      end
      rd_ready  = ($urandom_range(0, 99) < ready_pct);
      pix_valid = 1'($urandom_range(0, 1));
      pix_in    = 8'($urandom);
      pix_last  = 1'($urandom_range(0, 1));
      start     = ($urandom_range(0, 9) == 0);
      if (rd_valid && rd_ready) hs++;
      if (rd_valid_s && rd_ready) hs_s++;
      cyc++;
      if (hs < 256 || hs_s < 256) @(negedge clk);
    end
    check({name, ".handshakes"}, hs, 256);
    check({name, ".handshakes_s"}, hs_s, 256);
    @(negedge clk);
    start = 1'b0; pix_valid = 1'b0; pix_last = 1'b0; rd_ready = 1'b0;
    check({name, ".valid_after"}, rd_valid, 0);
    check({name, ".busy_after"}, busy, 0);
    check({name, ".valid_after_s"}, rd_valid_s, 0);
    check({name, ".sat"}, sat, exp_sat(MAX_L));
    check({name, ".sat_s"}, sat_s, exp_sat(MAX_S));
    $display("frame %s: %0d pixels, readout %0d cycles, failures so far %0d", name, pix_q.size(), cyc, n_fail);
  endtask

  task automatic run_frame(input string name, input int gap_pct, input int ready_pct, output int cyc);
    start_frame(name);
    send_pixels(gap_pct, 1'b1);
    readout(name, ready_pct, cyc);
  endtask

  initial begin
    int cyc;
    repeat (3) @(negedge clk);
    check("reset.busy", busy, 0);
    check("reset.pix_ready", pix_ready, 0);
    check("reset.rd_valid", rd_valid, 0);
    check("reset.rd_last", rd_last, 0);
    check("reset.rd_count", rd_count, 0);
    check("reset.sat", sat, 0);
    check("reset.busy_s", busy_s, 0);
    rst_n = 1'b1;
    @(negedge clk);

    pix_q = {};
    for (int i = 0; i < 256; i++) pix_q.push_back(i);
    run_frame("uniform", 0, 100, cyc);
    // READOUT is entered 2 edges after the last pixel, first word within 2 more, then one word per cycle.
    check("uniform.throughput", (cyc <= 260), 1);

    pix_q = {};
    repeat (1000) pix_q.push_back(8'h80);
    run_frame("run80", 0, 70, cyc);

    pix_q = {8'h10, 8'h10, 8'h20, 8'h10};
    run_frame("alt", 50, 50, cyc);

    pix_q = {};
    repeat (20) pix_q.push_back(5);
    run_frame("sat5", 0, 40, cyc);

    pix_q = {};
    repeat (600) pix_q.push_back(($urandom_range(0, 3) == 0) ? $urandom_range(0, 255) : $urandom_range(4, 7));
    run_frame("random", 30, 60, cyc);

    pix_q = {};
    repeat (100) pix_q.push_back($urandom_range(0, 3));
    start_frame("abort");
    send_pixels(10, 1'b0);
    rst_n = 1'b0;
    #1;
    check("abort.busy", busy, 0);
    check("abort.rd_valid", rd_valid, 0);
    check("abort.pix_ready", pix_ready, 0);
    check("abort.busy_s", busy_s, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check("abort.no_readout", rd_valid, 0);

    pix_q = {};
    repeat (10) pix_q.push_back(0);
    run_frame("after_abort", 0, 80, cyc);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/pixel_histogram.md
Name: pixel_histogram

Overview:
- Downstream consumer of the brightness/threshold pixel stage: takes its 8-bit processed output bytes and builds a 256-bin intensity histogram for one frame.
- After the frame ends, streams the bins out over a valid/ready interface to the next stage (equalisation LUT builder, or a file dump in the bench).
- Per frame, the block clears its internal RAM, accumulates pixels, then reads out the bins.

Parameters:
- PIX_W, 8, pixel width; number of bins = 2**PIX_W.
- CNT_W, 20, bin counter width; covers a 1024x1024 frame with saturation.

Ports:
- clk  in  1  single clock; all logic on posedge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse; begins clear of a new frame; honoured only in IDLE.
- pix_valid  in  1  pixel qualifier.
- pix_in  in  PIX_W  processed pixel (outbyte of the upstream stage).
- pix_last  in  1  marks the final pixel of the frame; meaningful only with pix_valid.
- pix_ready  out  1  high only in ACCUM.
- busy  out  1  high in any state other than IDLE.
- rd_valid  out  1  readout data valid.
- rd_ready  in  1  consumer ready.
- rd_bin  out  PIX_W  bin index of the current readout word.
- rd_count  out  CNT_W  bin count (or cumulative count, see the optional feature).
- rd_last  out  1  high with bin 2**PIX_W-1.
- sat  out  1  sticky flag: some bin saturated this frame.

Behaviour:
- Reset: on rst_n low, immediately enter IDLE. All outputs are 0 and all counters and pipeline registers are cleared. RAM contents are not reset.
- Reset mid-operation: aborts the frame with no partial readout.
- States: IDLE -> CLEAR -> ACCUM -> DRAIN -> READOUT -> IDLE.
- IDLE: start=1 -> CLEAR; sat is cleared on the same edge.
- CLEAR: writes 0 to bins 0..2**PIX_W-1, one per cycle, using an address counter. After exactly 256 cycles -> ACCUM.
- ACCUM: accepts one pixel per cycle when pix_valid && pix_ready.
  - 2-stage read-modify-write.
  - S1: register pix_in and issue a synchronous RAM read.
  - S2: compute count+1 and write back.
  - Forwarding: if the S1 address equals the S2 address (back-to-back identical pixels), S2 uses its own pending write value instead of the stale RAM data. A run of N equal pixels must yield exactly N.
  - Saturation: the increment is blocked at 2**CNT_W-1 and sat is set (sticky).
  - An accepted beat with pix_last=1 -> DRAIN.
- Pixels outside ACCUM: pix_valid with pix_ready=0 is ignored and never counted. A pix_last outside ACCUM is ignored.
- DRAIN: 2 cycles to retire the pipeline -> READOUT.
- READOUT:
  - Bin address counter starts at 0. rd_valid rises no more than 2 cycles after entering READOUT (RAM read latency plus output register).
  - Output stability: while rd_valid && !rd_ready, rd_bin, rd_count and rd_last hold stable.
  - Advance: each rd_valid && rd_ready handshake advances one bin. The block keeps 1 word/cycle throughput under continuous rd_ready using a prefetch/skid register.
  - Completion: the handshake on rd_last -> IDLE with rd_valid=0 in the next cycle.
- Other inputs: start outside IDLE is ignored. sat persists through READOUT until the next start.

Optional Feature:
- Macro: HIST_CUMULATIVE_EN.
- Defined: rd_count carries the running cumulative sum (CDF) over bins 0..k.
  - The accumulator is CNT_W wide and saturates at 2**CNT_W-1; saturation also sets sat.
  - The accumulator resets on entry to READOUT.
- Undefined: rd_count is the raw per-bin count.
- The interface is identical in both builds.

Decomposition:
- Shared package pixel_pkg holds:
  - PIX_W default.
  - Bin count constant NBINS = 256.
  - The state enum (IDLE, CLEAR, ACCUM, DRAIN, READOUT) as a 3-bit typedef.
- Sub-module hist_ram: 1R1W simple dual-port, synchronous read, depth 2**PIX_W, width CNT_W, no reset. It keeps the RAM inferable. Forwarding logic stays in pixel_histogram.

Test Plan:
- Uniform frame: start, then 256 pixels 0..255 with the last at 255 -> readout of 256 words each with count 1, rd_last on bin 255, sat=0.
- Back-to-back identical pixels: 1000 consecutive pixels of 8'h80, then pix_last -> bin 0x80 = 1000, all others 0 (checks forwarding).
- Alternating pixels 0x10,0x10,0x20,0x10 with pix_valid gaps -> bin 0x10 = 3, bin 0x20 = 1.
- Readout backpressure: toggle rd_ready randomly; no bin dropped or duplicated; data stable while stalled; exactly 256 handshakes.
- Saturation with CNT_W=4: 20 pixels of 0x05 -> bin 5 = 15, sat=1. With HIST_CUMULATIVE_EN, the CDF at bin 255 also equals 15.
- Reset mid-ACCUM: drop rst_n after 100 pixels -> busy=0, rd_valid=0 immediately. A new start plus 10 pixels of 0x00 -> bin 0 = 10, proving CLEAR wiped the stale counts.
